// File: rtl/prog_loader_if.sv
// Host-to-loader program word stream: load_start pulse plus valid/ready data words.
// The host drives the master modport; the loader takes the slave modport.
interface prog_loader_if #(
    parameter int INSTR_BITS = 16
);
    logic                  load_start;
    logic                  in_valid;
    logic                  in_ready;
    logic [INSTR_BITS-1:0] in_data;

    modport master (output load_start, in_valid, in_data, input in_ready);
    modport slave  (input load_start, in_valid, in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Instruction memory loader: length header, payload and zero fill, with a fetch read port; CHECKSUM_EN adds an XOR check word.
// Latency: fetch_instr is registered, valid 1 cycle after fetch_en; status outputs are registered.
// Backpressure: in_ready is high only while a header, payload or checksum word is expected.
module prog_loader #(
    parameter int ADDR_BITS  = 8,
    parameter int INSTR_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    prog_loader_if.slave          host,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_BITS:0]    words_loaded,
    input  logic                  fetch_en,
    input  logic [ADDR_BITS-1:0]  fetch_addr,
    output logic [INSTR_BITS-1:0] fetch_instr
);
    localparam int                 DEPTH_INT = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH     = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] LAST      = DEPTH - 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LOAD,
`ifdef CHECKSUM_EN
        CHECK,
`endif
        FILL,
        DONE,
        ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [ADDR_BITS:0]      words_q, words_d;
    logic [ADDR_BITS:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0]      n_q, n_d;
    logic [INSTR_BITS-1:0]   fetch_instr_q, fetch_instr_d;
`ifdef CHECKSUM_EN
    logic [INSTR_BITS-1:0]   csum_q, csum_d;
`endif

    logic                    accept;
    logic                    to_fill;
    logic                    ram_we;
    logic [INSTR_BITS-1:0]   ram_wdata;
    logic [ADDR_BITS:0]      hdr_n;
    logic                    hdr_bad;
    logic [INSTR_BITS-1:0]   ram [DEPTH_INT];

    assign accept  = host.in_valid & in_ready_q;
    assign hdr_n   = host.in_data[ADDR_BITS:0];
    assign hdr_bad = (hdr_n > DEPTH) || (|(host.in_data >> (ADDR_BITS + 1)));

    always_comb begin
        state_d       = state_q;
        in_ready_d    = in_ready_q;
        busy_d        = busy_q;
        done_d        = done_q;
        err_d         = err_q;
        words_d       = words_q;
        wr_ptr_d      = wr_ptr_q;
        n_d           = n_q;
`ifdef CHECKSUM_EN
        csum_d        = csum_q;
`endif
        to_fill       = 1'b0;
        ram_we        = 1'b0;
        ram_wdata     = '0;
        fetch_instr_d = fetch_instr_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (host.load_start) begin
                    state_d    = LEN;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    words_d    = '0;
                    wr_ptr_d   = '0;
`ifdef CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            LEN: begin
                if (accept) begin
                    if (hdr_bad) begin
                        state_d    = ERROR;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        err_d      = 1'b1;
                    end else begin
                        n_d = hdr_n;
                        if (hdr_n == '0) begin
`ifdef CHECKSUM_EN
                            state_d = CHECK;
`else
                            to_fill = 1'b1;
`endif
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    ram_we    = 1'b1;
                    ram_wdata = host.in_data;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    words_d   = words_q + 1'b1;
`ifdef CHECKSUM_EN
                    csum_d    = csum_q ^ host.in_data;
`endif
                    if (wr_ptr_d == n_q) begin
`ifdef CHECKSUM_EN
                        state_d = CHECK;
`else
                        to_fill = 1'b1;
`endif
                    end
                end
            end
`ifdef CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (host.in_data == csum_q) begin
                        to_fill = 1'b1;
                    end else begin
                        state_d    = ERROR;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        err_d      = 1'b1;
                    end
                end
            end
`endif
            FILL: begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A full-depth program has nothing left to pad, so it completes immediately.
        if (to_fill) begin
            in_ready_d = 1'b0;
            if (wr_ptr_d == DEPTH) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = FILL;
            end
        end

        // Fetch sees only a complete program; anything else reads as NOP.
        if (fetch_en) begin
            fetch_instr_d = done_q ? ram[fetch_addr] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            words_q       <= '0;
            wr_ptr_q      <= '0;
            n_q           <= '0;
            fetch_instr_q <= '0;
`ifdef CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            words_q       <= words_d;
            wr_ptr_q      <= wr_ptr_d;
            n_q           <= n_d;
            fetch_instr_q <= fetch_instr_d;
`ifdef CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[wr_ptr_q[ADDR_BITS-1:0]] <= ram_wdata;
        end
    end

    assign host.in_ready = in_ready_q;
    assign load_busy     = busy_q;
    assign load_done     = done_q;
    assign load_error    = err_q;
    assign words_loaded  = words_q;
    assign fetch_instr   = fetch_instr_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader against an array model of the instruction memory.
module tb_prog_loader;
    localparam int AB    = 8;
    localparam int IB    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_busy, load_done, load_error;
    logic [AB:0]   words_loaded;
    logic          fetch_en;
    logic [AB-1:0] fetch_addr;
    logic [IB-1:0] fetch_instr;

    int checks = 0;
    int errors = 0;

    logic [IB-1:0] model_ram [DEPTH];
    bit            model_loaded = 1'b0;
    logic [IB-1:0] prog [$];

    always #5 clk = ~clk;

    prog_loader_if #(.INSTR_BITS(IB)) host();

    prog_loader #(.ADDR_BITS(AB), .INSTR_BITS(IB)) dut (
        .clk          (clk),
        .reset        (reset),
        .host         (host),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded),
        .fetch_en     (fetch_en),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        host.load_start = 1'b1;
        tick();
        host.load_start = 1'b0;
    endtask

    task automatic send(input logic [IB-1:0] w);
        int t = 0;
        host.in_valid = 1'b1;
        host.in_data  = w;
        while (!host.in_ready && t < 50) begin
            tick();
            t++;
        end
        check("send_ready", 32'(host.in_ready), 32'd1);
        tick();
        host.in_valid = 1'b0;
    endtask

    function automatic logic [IB-1:0] model_word(input int a);
        return model_loaded ? model_ram[a] : '0;
    endfunction

    task automatic fetch_check(input int a, input string tag);
        fetch_en   = 1'b1;
        fetch_addr = AB'(a);
        tick();
        check(tag, 32'(fetch_instr), 32'(model_word(a)));
    endtask

    task automatic verify_all();
        for (int a = 0; a < DEPTH; a++) fetch_check(a, "ram_image");
    endtask

    task automatic rand_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(IB'($urandom));
    endtask

    function automatic logic [IB-1:0] prog_xor();
        logic [IB-1:0] x = '0;
        foreach (prog[i]) x ^= prog[i];
        return x;
    endfunction

    task automatic run_load(input int stall_at, input bit poke);
        int n = prog.size();
        int cyc = 0;
        model_loaded = 1'b0;
        pulse_start();
        check("len_busy", 32'(load_busy), 32'd1);
        check("len_ready", 32'(host.in_ready), 32'd1);
        check("len_done_clear", 32'(load_done), 32'd0);
        check("len_words_clear", 32'(words_loaded), 32'd0);
        send(IB'(n));
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                repeat (4) begin
                    tick();
                    check("stall_words_hold", 32'(words_loaded), 32'(i));
                end
                if (poke) begin
                    pulse_start();
                    check("start_ignored_words", 32'(words_loaded), 32'(i));
                    check("start_ignored_ready", 32'(host.in_ready), 32'd1);
                end
            end
            send(prog[i]);
            check("words_loaded", 32'(words_loaded), 32'(i + 1));
        end
`ifdef CHECKSUM_EN
        send(prog_xor());
`endif
        while (!load_done && !load_error && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("fill_cycles", 32'(cyc), 32'(DEPTH - n));
        check("done_set", 32'(load_done), 32'd1);
        check("done_busy", 32'(load_busy), 32'd0);
        check("done_err", 32'(load_error), 32'd0);
        check("done_ready", 32'(host.in_ready), 32'd0);
        for (int a = 0; a < DEPTH; a++) model_ram[a] = (a < n) ? prog[a] : '0;
        model_loaded = 1'b1;
    endtask

    task automatic bad_header(input logic [IB-1:0] hdr);
        model_loaded = 1'b0;
        pulse_start();
        send(hdr);
        check("hdr_err", 32'(load_error), 32'd1);
        check("hdr_ready", 32'(host.in_ready), 32'd0);
        check("hdr_done", 32'(load_done), 32'd0);
        check("hdr_busy", 32'(load_busy), 32'd0);
        fetch_check(1, "hdr_fetch_nop");
    endtask

    initial begin
        logic [IB-1:0] held;
        reset           = 1'b1;
        host.load_start = 1'b0;
        host.in_valid   = 1'b0;
        host.in_data    = '0;
        fetch_en        = 1'b1;
        fetch_addr      = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_ready", 32'(host.in_ready), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        tick();
        check("rst_fetch", 32'(fetch_instr), 32'h0);

        // Reference program from the datasheet example.
        prog.delete();
        prog.push_back(16'h910A);
        prog.push_back(16'h311E);
        prog.push_back(16'h7210);
        run_load(-1, 1'b0);
        fetch_check(1, "ex_addr1");
        check("ex_addr1_const", 32'(fetch_instr), 32'h311E);
        fetch_check(5, "ex_addr5");
        check("ex_addr5_const", 32'(fetch_instr), 32'h0);

        // Random program with a 4-cycle host stall and an ignored load_start.
        rand_prog($urandom_range(60, 8));
        run_load(prog.size() / 2, 1'b1);
        verify_all();

        // Oversized header, then restart, then an out-of-range high bit.
        bad_header(16'h0101);
        pulse_start();
        check("restart_ready", 32'(host.in_ready), 32'd1);
        check("restart_busy", 32'(load_busy), 32'd1);
        check("restart_err_clr", 32'(load_error), 32'd0);
        send(16'h8003);
        check("hibit_err", 32'(load_error), 32'd1);

        // Full-depth program: no fill phase.
        rand_prog(DEPTH);
        run_load(-1, 1'b0);
        verify_all();

        // Empty program: whole memory padded with NOP.
        prog.delete();
        run_load(-1, 1'b0);
        fetch_check(0, "empty_0");
        fetch_check(255, "empty_255");

        // Reset after two payload words.
        rand_prog(10);
        pulse_start();
        send(16'd10);
        send(prog[0]);
        send(prog[1]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_loaded = 1'b0;
        check("midrst_done", 32'(load_done), 32'd0);
        check("midrst_busy", 32'(load_busy), 32'd0);
        check("midrst_ready", 32'(host.in_ready), 32'd0);
        check("midrst_words", 32'(words_loaded), 32'd0);
        fetch_check(0, "midrst_fetch0");
        fetch_check(1, "midrst_fetch1");
        host.in_valid = 1'b1;
        tick();
        check("idle_no_ready", 32'(host.in_ready), 32'd0);
        host.in_valid = 1'b0;
        rand_prog(10);
        run_load(-1, 1'b0);
        verify_all();

        // fetch_en low holds the last fetched word.
        fetch_check(3, "hold_src");
        held       = model_word(3);
        fetch_en   = 1'b0;
        fetch_addr = 8'd7;
        tick();
        tick();
        check("fetch_hold", 32'(fetch_instr), 32'(held));

`ifdef CHECKSUM_EN
        // Corrupted checksum word.
        rand_prog(5);
        model_loaded = 1'b0;
        pulse_start();
        send(16'd5);
        foreach (prog[i]) send(prog[i]);
        send(prog_xor() ^ 16'h0001);
        check("csum_err", 32'(load_error), 32'd1);
        check("csum_done", 32'(load_done), 32'd0);
        fetch_check(0, "csum_fetch_nop");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
